// File: rtl/conv_event_fanout_if.sv
// Event-in / FIFO-write-out bundle for conv_event_fanout.
// master: event source plus FIFO status; slave: the fan-out block.
interface conv_event_fanout_if #(
    parameter int unsigned CH_I_W = 8,
    parameter int unsigned CH_O_W = 7,
    parameter int unsigned POS_W  = 2,
    parameter int unsigned K      = 3,
    parameter int unsigned K_W    = 2
);
    localparam int unsigned DW    = CH_I_W + 2 * K_W + CH_O_W + 2 * POS_W;
    localparam int unsigned CNT_W = $clog2(K * K + 1);

    logic [CH_I_W-1:0] in_ch_i;
    logic [POS_W-1:0]  in_x;
    logic [POS_W-1:0]  in_y;
    logic [CH_O_W-1:0] in_ch_o;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              wr_en;
    logic              full;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output in_ch_i, in_x, in_y, in_ch_o, in_valid, full,
        input  in_ready, out_data, wr_en, done, err, wr_cnt
    );

    modport slave (
        input  in_ch_i, in_x, in_y, in_ch_o, in_valid, full,
        output in_ready, out_data, wr_en, done, err, wr_cnt
    );
endinterface

// File: rtl/conv_event_fanout.sv
// Spike-event fan-out for a KxK stride-1 zero-padded convolution.
// One accepted event (ch_i, x, y, ch_o) is expanded into every (tap, output pixel)
// pair it reaches; each valid pair is written to the conv FIFO, one word per cycle.
module conv_event_fanout #(
    parameter int unsigned CH_I_W = 8,
    parameter int unsigned CH_O_W = 7,
    parameter int unsigned POS_W  = 2,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned IN_H   = 4,
    parameter int unsigned K      = 3,
    parameter int unsigned K_W    = 2,
    parameter int unsigned PAD    = 1
) (
    input logic                clk,
    input logic                rst,
    conv_event_fanout_if.slave bus
);
    localparam int unsigned OUT_W = IN_W + 2 * PAD - K + 1;
    localparam int unsigned OUT_H = IN_H + 2 * PAD - K + 1;
    localparam int unsigned DW    = CH_I_W + 2 * K_W + CH_O_W + 2 * POS_W;
    localparam int unsigned CNT_W = $clog2(K * K + 1);
    // Signed width for output-pixel arithmetic; assumes POS_W + 2 > K_W.
    localparam int unsigned SW    = POS_W + 2;

    localparam logic signed [SW-1:0] PadS  = SW'(PAD);
    localparam logic signed [SW-1:0] OutWS = SW'(OUT_W);
    localparam logic signed [SW-1:0] OutHS = SW'(OUT_H);
    localparam logic [K_W-1:0]       KLast = K_W'(K - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [CH_I_W-1:0] ch_i_q, ch_i_d;
    logic [CH_O_W-1:0] ch_o_q, ch_o_d;
    logic [POS_W-1:0]  x_q, x_d;
    logic [POS_W-1:0]  y_q, y_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic signed [SW-1:0] ox_s, oy_s;
    logic                 cand_valid;
    logic                 in_oob;
    logic                 in_ready_c;
    logic                 wr_en_c;
    logic                 advance;

    // Candidate output pixel for the current tap and its bounds check.
    always_comb begin
        ox_s = $signed({2'b00, x_q}) + PadS - $signed({{(SW - K_W){1'b0}}, kx_q});
        oy_s = $signed({2'b00, y_q}) + PadS - $signed({{(SW - K_W){1'b0}}, ky_q});
        cand_valid = !ox_s[SW-1] && (ox_s < OutWS) && !oy_s[SW-1] && (oy_s < OutHS);
        in_oob = (int'(bus.in_x) >= int'(IN_W)) || (int'(bus.in_y) >= int'(IN_H));
    end

    // Next-state logic: accept in IDLE, one candidate tap per cycle in SCAN.
    always_comb begin
        state_d    = state_q;
        ch_i_d     = ch_i_q;
        ch_o_d     = ch_o_q;
        x_d        = x_q;
        y_d        = y_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        cnt_d      = cnt_q;
        wr_cnt_d   = wr_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        in_ready_c = 1'b0;
        wr_en_c    = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    ch_i_d = bus.in_ch_i;
                    ch_o_d = bus.in_ch_o;
                    x_d    = bus.in_x;
                    y_d    = bus.in_y;
                    kx_d   = '0;
                    ky_d   = '0;
                    cnt_d  = '0;
                    if (in_oob) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                wr_en_c = cand_valid && !bus.full;
                // A valid tap blocked by full is retried; invalid taps always move on.
                advance = !cand_valid || !bus.full;
                if (advance) begin
                    cnt_d = cnt_q + CNT_W'(wr_en_c);
                    if (ky_q == KLast) begin
                        ky_d = '0;
                        if (kx_q == KLast) begin
                            state_d  = StIdle;
                            done_d   = 1'b1;
                            wr_cnt_d = cnt_q + CNT_W'(wr_en_c);
                        end else begin
                            kx_d = kx_q + K_W'(1);
                        end
                    end else begin
                        ky_d = ky_q + K_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_i_q   <= '0;
            ch_o_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            kx_q     <= '0;
            ky_q     <= '0;
            cnt_q    <= '0;
            wr_cnt_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_i_q   <= ch_i_d;
            ch_o_q   <= ch_o_d;
            x_q      <= x_d;
            y_q      <= y_d;
            kx_q     <= kx_d;
            ky_q     <= ky_d;
            cnt_q    <= cnt_d;
            wr_cnt_q <= wr_cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign bus.in_ready = in_ready_c && !rst;
    assign bus.wr_en    = wr_en_c && !rst;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.wr_cnt   = wr_cnt_q;
    assign bus.out_data = DW'({ch_i_q, kx_q, ky_q, ch_o_q, ox_s[POS_W-1:0], oy_s[POS_W-1:0]});

endmodule

// File: tb/tb_conv_event_fanout.sv
// Directed bench for conv_event_fanout: default build, a wide-coordinate build for
// out-of-range events, and a K=5 build.
module tb_conv_event_fanout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_event_fanout_if #(.CH_I_W(8), .CH_O_W(7), .POS_W(2), .K(3), .K_W(2)) bus_m ();
    conv_event_fanout_if #(.CH_I_W(8), .CH_O_W(7), .POS_W(3), .K(3), .K_W(2)) bus_w ();
    conv_event_fanout_if #(.CH_I_W(8), .CH_O_W(7), .POS_W(3), .K(5), .K_W(3)) bus_s ();

    conv_event_fanout #(
        .CH_I_W(8), .CH_O_W(7), .POS_W(2), .IN_W(4), .IN_H(4), .K(3), .K_W(2), .PAD(1)
    ) u_main (.clk(clk), .rst(rst), .bus(bus_m));

    conv_event_fanout #(
        .CH_I_W(8), .CH_O_W(7), .POS_W(3), .IN_W(4), .IN_H(4), .K(3), .K_W(2), .PAD(1)
    ) u_wide (.clk(clk), .rst(rst), .bus(bus_w));

    conv_event_fanout #(
        .CH_I_W(8), .CH_O_W(7), .POS_W(3), .IN_W(8), .IN_H(8), .K(5), .K_W(3), .PAD(2)
    ) u_sweep (.clk(clk), .rst(rst), .bus(bus_s));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int base_cyc = 0;
    int bad_full = 0;
    int wide_wr = 0;
    logic [22:0] wq[$];
    int          wc[$];
    logic [22:0] fq[$];
    logic [26:0] sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus_m.wr_en) begin
            wq.push_back(bus_m.out_data);
            wc.push_back(cyc);
            if (bus_m.full) bad_full++;
        end
        if (bus_w.wr_en) wide_wr++;
        if (bus_s.wr_en) sq.push_back(bus_s.out_data);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] mk(input int ci, input int kx, input int ky,
                                       input int co, input int ox, input int oy);
        return {ci[7:0], kx[1:0], ky[1:0], co[6:0], ox[1:0], oy[1:0]};
    endfunction

    // Present one event to the default build, then step cycles applying the full mask
    // until done (or the bound expires, leaving done_c = -1).
    task automatic run_main(input int ci, input int x, input int y, input int co,
                            input logic [63:0] fmask, output int done_c);
        wq.delete();
        wc.delete();
        fq.delete();
        @(posedge clk);
        #1;
        bus_m.in_ch_i  = ci[7:0];
        bus_m.in_x     = x[1:0];
        bus_m.in_y     = y[1:0];
        bus_m.in_ch_o  = co[6:0];
        bus_m.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_m.in_valid = 1'b0;
        base_cyc = cyc;
        done_c = -1;
        for (int c = 1; c <= 60; c++) begin
            bus_m.full = fmask[c];
            @(negedge clk);
            if (fmask[c]) fq.push_back(bus_m.out_data);
            if (bus_m.done) begin
                done_c = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus_m.full = 1'b0;
    endtask

    initial begin
        int done_c;
        logic [22:0] exp_w[4];
        int exp_c[4];
        logic [22:0] w1_lit;

        bus_m.in_valid = 1'b0; bus_m.full = 1'b0; bus_m.in_ch_i = '0; bus_m.in_ch_o = '0;
        bus_m.in_x = '0; bus_m.in_y = '0;
        bus_w.in_valid = 1'b0; bus_w.full = 1'b0; bus_w.in_ch_i = '0; bus_w.in_ch_o = '0;
        bus_w.in_x = '0; bus_w.in_y = '0;
        bus_s.in_valid = 1'b0; bus_s.full = 1'b0; bus_s.in_ch_i = '0; bus_s.in_ch_o = '0;
        bus_s.in_x = '0; bus_s.in_y = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus_m.in_ready, 0);
        chk("rst_wr_en", bus_m.wr_en, 0);
        chk("rst_done", bus_m.done, 0);
        chk("rst_err", bus_m.err, 0);
        chk("rst_wr_cnt", bus_m.wr_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus_m.in_ready, 1);

        // Corner event (0,0).
        run_main(5, 0, 0, 3, 64'd0, done_c);
        exp_w[0] = mk(5, 0, 0, 3, 1, 1); exp_w[1] = mk(5, 0, 1, 3, 1, 0);
        exp_w[2] = mk(5, 1, 0, 3, 0, 1); exp_w[3] = mk(5, 1, 1, 3, 0, 0);
        exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 4; exp_c[3] = 5;
        w1_lit = {8'd5, 2'd0, 2'd0, 7'd3, 2'd1, 2'd1};
        chk("corner_done_lat", done_c, 10);
        chk("corner_wr_cnt", bus_m.wr_cnt, 4);
        chk("corner_in_ready", bus_m.in_ready, 1);
        chk("corner_nwr", wq.size(), 4);
        if (wq.size() > 0) chk("corner_word1_lit", wq[0], w1_lit);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk($sformatf("corner_word%0d", i), wq[i], exp_w[i]);
            chk($sformatf("corner_cyc%0d", i), wc[i] - base_cyc + 1, exp_c[i]);
        end

        // Interior event (1,2): nine consecutive writes.
        run_main(9, 1, 2, 4, 64'd0, done_c);
        chk("int_done_lat", done_c, 10);
        chk("int_wr_cnt", bus_m.wr_cnt, 9);
        chk("int_nwr", wq.size(), 9);
        for (int i = 0; i < 9 && i < wq.size(); i++) begin
            chk($sformatf("int_word%0d", i), wq[i], mk(9, i / 3, i % 3, 4, 2 - i / 3, 3 - i % 3));
            chk($sformatf("int_cyc%0d", i), wc[i] - base_cyc + 1, i + 1);
        end

        // Opposite corner (3,3).
        run_main(17, 3, 3, 100, 64'd0, done_c);
        chk("opp_done_lat", done_c, 10);
        chk("opp_wr_cnt", bus_m.wr_cnt, 4);
        chk("opp_nwr", wq.size(), 4);
        exp_w[0] = mk(17, 1, 1, 100, 3, 3); exp_w[1] = mk(17, 1, 2, 100, 3, 2);
        exp_w[2] = mk(17, 2, 1, 100, 2, 3); exp_w[3] = mk(17, 2, 2, 100, 2, 2);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            chk($sformatf("opp_word%0d", i), wq[i], exp_w[i]);

        // Backpressure: full high for cycles 2..4, at the second valid write.
        run_main(5, 0, 0, 3, 64'b1_1100, done_c);
        exp_w[0] = mk(5, 0, 0, 3, 1, 1); exp_w[1] = mk(5, 0, 1, 3, 1, 0);
        exp_w[2] = mk(5, 1, 0, 3, 0, 1); exp_w[3] = mk(5, 1, 1, 3, 0, 0);
        exp_c[0] = 1; exp_c[1] = 5; exp_c[2] = 7; exp_c[3] = 8;
        chk("bp_done_lat", done_c, 13);
        chk("bp_wr_cnt", bus_m.wr_cnt, 4);
        chk("bp_nwr", wq.size(), 4);
        chk("bp_nfrozen", fq.size(), 3);
        for (int i = 0; i < fq.size(); i++)
            chk($sformatf("bp_frozen%0d", i), fq[i], exp_w[1]);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk($sformatf("bp_word%0d", i), wq[i], exp_w[i]);
            chk($sformatf("bp_cyc%0d", i), wc[i] - base_cyc + 1, exp_c[i]);
        end
        chk("bp_no_wr_when_full", bad_full, 0);

        // Out of range on the wide build, then a back-to-back valid event.
        wide_wr = 0;
        @(posedge clk);
        #1;
        bus_w.in_ch_i = 8'd2; bus_w.in_ch_o = 7'd1;
        bus_w.in_x = 3'd4; bus_w.in_y = 3'd0; bus_w.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_w.in_x = 3'd0;
        @(negedge clk);
        chk("oob_err", bus_w.err, 1);
        chk("oob_in_ready", bus_w.in_ready, 1);
        chk("oob_wr_en", bus_w.wr_en, 0);
        chk("oob_done", bus_w.done, 0);
        @(posedge clk);
        #1;
        bus_w.in_valid = 1'b0;
        done_c = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("b2b_err_clear", bus_w.err, 0);
                chk("b2b_in_ready", bus_w.in_ready, 0);
            end
            if (bus_w.done) begin
                done_c = c;
                break;
            end
            @(posedge clk);
        end
        chk("b2b_done_lat", done_c, 10);
        chk("b2b_nwr", wide_wr, 4);
        chk("b2b_wr_cnt", bus_w.wr_cnt, 4);

        // Reset in the middle of an interior scan, after two writes.
        wq.delete();
        @(posedge clk);
        #1;
        bus_m.in_ch_i = 8'd9; bus_m.in_ch_o = 7'd4;
        bus_m.in_x = 2'd1; bus_m.in_y = 2'd2; bus_m.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_m.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_wr_en_a", bus_m.wr_en, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_wr_en_b", bus_m.wr_en, 0);
        chk("mrst_in_ready", bus_m.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_done%0d", i), bus_m.done, 0);
            chk($sformatf("mrst_idle_wr%0d", i), bus_m.wr_en, 0);
            chk($sformatf("mrst_ready%0d", i), bus_m.in_ready, 1);
        end
        chk("mrst_nwr", wq.size(), 2);
        if (wq.size() > 1) begin
            chk("mrst_word0", wq[0], mk(9, 0, 0, 4, 2, 3));
            chk("mrst_word1", wq[1], mk(9, 0, 1, 4, 2, 2));
        end
        chk("mrst_wr_cnt", bus_m.wr_cnt, 0);
        run_main(5, 0, 0, 3, 64'd0, done_c);
        chk("post_done_lat", done_c, 10);
        chk("post_wr_cnt", bus_m.wr_cnt, 4);
        chk("post_nwr", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            chk($sformatf("post_word%0d", i), wq[i], exp_w[i]);

        // K=5 build, event (0,0): nine writes over 25 scan cycles.
        sq.delete();
        @(posedge clk);
        #1;
        bus_s.in_ch_i = 8'd7; bus_s.in_ch_o = 7'd2;
        bus_s.in_x = 3'd0; bus_s.in_y = 3'd0; bus_s.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        done_c = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus_s.done) begin
                done_c = c;
                break;
            end
            @(posedge clk);
        end
        chk("sweep_done_lat", done_c, 26);
        chk("sweep_nwr", sq.size(), 9);
        chk("sweep_wr_cnt", bus_s.wr_cnt, 9);
        if (sq.size() == 9) begin
            chk("sweep_first", sq[0], {8'd7, 3'd0, 3'd0, 7'd2, 3'd2, 3'd2});
            chk("sweep_last", sq[8], {8'd7, 3'd2, 3'd2, 7'd2, 3'd0, 3'd0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
